// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: program counter, instruction word and fetch-queue entry.
package cpu_pkg;

    typedef logic [15:0] pc_t;
    typedef logic [15:0] instr_t;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fq_entry_t;

    localparam pc_t RESET_PC = 16'h0;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: if_stage capture handshake plus decode-side head handshake.
interface fetch_queue_if
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    pc_t              if_pc;
    instr_t           if_instr;
    logic             pc_en;
    logic             id_valid;
    logic             id_ready;
    pc_t              id_pc;
    instr_t           id_instr;
    logic [CNT_W-1:0] count;

    // master: the surrounding pipeline (if_stage, decode, EX redirect)
    modport master (
        output flush, if_pc, if_instr, id_ready,
        input  pc_en, id_valid, id_pc, id_instr, count
    );

    // slave: the queue itself
    modport slave (
        input  flush, if_pc, if_instr, id_ready,
        output pc_en, id_valid, id_pc, id_instr, count
    );

endinterface

// File: rtl/fq_ptr.sv
// Wrap-around queue pointer with increment enable and synchronous clear (clear wins).
module fq_ptr #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between if_stage and decode; absorbs decode stalls and drops wrong-path
// work on flush. Optional zero-latency bypass when empty: `define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fq_entry_t        mem [DEPTH];
    fq_entry_t        head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;

    logic empty_c;
    logic full_c;
    logic id_valid_c;
    logic pop_c;
    logic push_c;
    logic store_c;
    logic drain_c;
    logic bypass_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_c = empty_c & bus.id_ready & ~bus.flush;
`else
    assign bypass_c = 1'b0;
`endif

    // Handshakes; a bypassed pair is consumed straight from if_stage and never stored.
    assign id_valid_c = ~empty_c | bypass_c;
    assign pop_c      = id_valid_c & bus.id_ready;
    assign bus.pc_en  = bus.flush | ~full_c | pop_c;
    assign push_c     = bus.pc_en & ~bus.flush;
    assign store_c    = push_c & ~bypass_c;
    assign drain_c    = pop_c & ~empty_c;

    fq_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (store_c),
        .clr   (bus.flush),
        .ptr   (wr_ptr)
    );

    fq_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (drain_c),
        .clr   (bus.flush),
        .ptr   (rd_ptr)
    );

    // Storage carries no reset; count alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (store_c) begin
            mem[wr_ptr] <= '{pc: bus.if_pc, instr: bus.if_instr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (bus.flush) begin
            count_q <= '0;
        end else if (store_c && !drain_c) begin
            count_q <= count_q + CNT_W'(1);
        end else if (drain_c && !store_c) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign head = mem[rd_ptr];

    // Head presentation; reads zero while empty so decode never sees stale storage.
    always_comb begin
        bus.id_pc    = '0;
        bus.id_instr = '0;
        if (!empty_c) begin
            bus.id_pc    = head.pc;
            bus.id_instr = head.instr;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (bypass_c) begin
            bus.id_pc    = bus.if_pc;
            bus.id_instr = bus.if_instr;
        end
`endif
    end

    assign bus.id_valid = id_valid_c;
    assign bus.count    = count_q;

endmodule
